// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, with bursts ending on last or MAX_BURST beats.
// Optional idle-release timeout compiled in with `define FIFO_ARB_TIMEOUT_EN.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic                      write_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      full,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   gidx, gidx_nxt;
  logic [IDX_W-1:0]   last_grant, last_grant_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  int unsigned        cand;

  logic               in_burst;
  logic               g_valid;
  logic               g_last;
  logic               burst_done;
  logic               timeout_hit;
  logic               release_now;

  // First valid requester searching upward from last_grant+1, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_grant) + i) % NUM_REQ;
      if (!pick_found && req_valid[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign in_burst = (state == BURST);
  assign g_valid  = req_valid[gidx];
  assign g_last   = req_last[gidx];
  assign busy     = in_burst;
  assign wr_en    = in_burst & g_valid & ~full & ~rst;
  assign wr_data  = in_burst ? req_data[gidx*DATA_W +: DATA_W] : '0;

  always_comb begin
    req_ready = '0;
    if (in_burst && !full && !rst) req_ready[gidx] = 1'b1;
  end

  assign burst_done = wr_en & (g_last | (cnt == CNT_W'(MAX_BURST - 1)));

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Only cycles where the granted requester is not valid count; full stalls with valid high clear it.
  assign timeout_hit = in_burst & ~g_valid & (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge write_clk) begin
    if (rst || !in_burst || g_valid || timeout_hit) idle_cnt <= '0;
    else                                            idle_cnt <= idle_cnt + 1'b1;
  end
`else
  // Timeout logic compiled out; the granted requester may hold the port indefinitely.
  assign timeout_hit = 1'b0 & (TIMEOUT != 0);
`endif

  assign release_now = burst_done | timeout_hit;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    gidx_nxt       = gidx;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt           = BURST;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          gidx_nxt            = pick_idx;
          cnt_nxt             = '0;
        end
      end
      BURST: begin
        if (wr_en) cnt_nxt = cnt + 1'b1;
        if (release_now) begin
          state_nxt      = IDLE;
          grant_nxt      = '0;
          last_grant_nxt = gidx;
          cnt_nxt        = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      gidx       <= gidx_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table for reset/round-robin/full/reset-mid-burst,
// plus hand sequences for burst splitting and grant hold / idle timeout.
module tb_fifo_write_arbiter;

  logic        write_clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic        full;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fifo_write_arbiter #(
    .NUM_REQ  (4),
    .DATA_W   (8),
    .MAX_BURST(4),
    .TIMEOUT  (8)
  ) dut (
    .write_clk(write_clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_data (req_data),
    .full     (full),
    .req_ready(req_ready),
    .grant    (grant),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [31:0] data;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic        e_wr;
    logic [7:0]  e_data;
    logic [3:0]  e_ready;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic f, input logic [31:0] d, input logic [3:0] eg,
                              input logic eb, input logic ew, input logic [7:0] ed,
                              input logic [3:0] er);
    vec_t t;
    t.rst = r; t.valid = v; t.last = l; t.full = f; t.data = d;
    t.e_grant = eg; t.e_busy = eb; t.e_wr = ew; t.e_data = ed; t.e_ready = er;
    vq.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, far from the rising edge.
  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic f, input logic [31:0] d);
    @(negedge write_clk);
    rst = r; req_valid = v; req_last = l; full = f; req_data = d;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    int kmax;
    rst = 1'b1; req_valid = '0; req_last = '0; full = 1'b0; req_data = '0;

    // Reset, then single 3-beat packet from requester 0
    add(1, 4'b0001, 4'b0000, 0, 32'h000000A1, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b0001, 4'b0000, 0, 32'h000000A1, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b0001, 4'b0000, 0, 32'h000000A1, 4'b0001, 1, 1, 8'hA1, 4'b0001);
    add(0, 4'b0001, 4'b0000, 0, 32'h000000A2, 4'b0001, 1, 1, 8'hA2, 4'b0001);
    add(0, 4'b0001, 4'b0001, 0, 32'h000000A3, 4'b0001, 1, 1, 8'hA3, 4'b0001);
    add(0, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 4'b0000);
    // Round robin, all requesting single-beat packets
    add(1, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0001, 1, 1, 8'h11, 4'b0001);
    add(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0010, 1, 1, 8'h22, 4'b0010);
    add(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0100, 1, 1, 8'h33, 4'b0100);
    add(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b1000, 1, 1, 8'h44, 4'b1000);
    add(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0001, 1, 1, 8'h11, 4'b0001);
    add(0, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 4'b0000);
    // Full stall of 5 cycles inside a burst from requester 2
    add(0, 4'b0100, 4'b0000, 0, 32'h00C10000, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b0100, 4'b0000, 0, 32'h00C10000, 4'b0100, 1, 1, 8'hC1, 4'b0100);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0100, 4'b0000, 1, 32'h00C20000, 4'b0100, 1, 0, 8'hC2, 4'b0000);
    add(0, 4'b0100, 4'b0000, 0, 32'h00C20000, 4'b0100, 1, 1, 8'hC2, 4'b0100);
    add(0, 4'b0100, 4'b0100, 0, 32'h00C30000, 4'b0100, 1, 1, 8'hC3, 4'b0100);
    add(0, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 4'b0000);
    // Reset during beat 2 of requester 2; priority back to requester 0
    add(0, 4'b0100, 4'b0000, 0, 32'h00D10000, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b0100, 4'b0000, 0, 32'h00D10000, 4'b0100, 1, 1, 8'hD1, 4'b0100);
    add(1, 4'b0100, 4'b0000, 0, 32'h00D20000, 4'b0100, 1, 0, 8'hD2, 4'b0000);
    add(1, 4'b0100, 4'b0000, 0, 32'h00D20000, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b0101, 4'b0000, 0, 32'h00E200E0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b0101, 4'b0001, 0, 32'h00E200E0, 4'b0001, 1, 1, 8'hE0, 4'b0001);
    add(0, 4'b0100, 4'b0100, 0, 32'h00E200E0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    add(0, 4'b0100, 4'b0100, 0, 32'h00E200E0, 4'b0100, 1, 1, 8'hE2, 4'b0100);
    add(0, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 4'b0000);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].valid, vq[i].last, vq[i].full, vq[i].data);
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(vq[i].e_grant));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].e_busy));
      chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vq[i].e_wr));
      chk($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(vq[i].e_data));
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vq[i].e_ready));
    end

    // Requester 1 streams 10 beats without last: bursts 4,4,2 separated by one arbitration cycle
    nb = 1;
    for (int c = 0; c < 13; c++) begin
      drive(0, 4'b0010, 4'b0000, 0, {16'h0, 8'(8'h50 + nb), 8'h00});
      if (c % 5 != 0) begin
        chk($sformatf("stream c%0d wr_en", c), 32'(wr_en), 32'd1);
        chk($sformatf("stream c%0d wr_data", c), 32'(wr_data), 32'(8'h50 + nb));
        chk($sformatf("stream c%0d grant", c), 32'(grant), 32'b0010);
        nb++;
      end else begin
        chk($sformatf("stream c%0d wr_en", c), 32'(wr_en), 32'd0);
        chk($sformatf("stream c%0d grant", c), 32'(grant), 32'b0000);
      end
    end
    drive(0, 4'b0000, 4'b0000, 0, 32'h0);
    chk("stream held grant", 32'(grant), 32'b0010);
    chk("stream held wr_en", 32'(wr_en), 32'd0);
    chk("stream beat count", 32'(nb), 32'd11);

    // Granted requester 3 goes quiet while requester 1 requests
    drive(1, 4'b0000, 4'b0000, 0, 32'h0);
    drive(0, 4'b1000, 4'b0000, 0, 32'h77000000);
    chk("hold arb grant", 32'(grant), 32'b0000);
    drive(0, 4'b1000, 4'b0000, 0, 32'h77000000);
    chk("hold first beat", 32'(wr_en), 32'd1);
`ifdef FIFO_ARB_TIMEOUT_EN
    kmax = 10;
`else
    kmax = 50;
`endif
    for (int k = 1; k <= kmax; k++) begin
      drive(0, 4'b0010, 4'b0000, 0, 32'h00005500);
`ifdef FIFO_ARB_TIMEOUT_EN
      if (k <= 8) begin
        chk($sformatf("timeout k%0d grant", k), 32'(grant), 32'b1000);
        chk($sformatf("timeout k%0d wr_en", k), 32'(wr_en), 32'd0);
      end else if (k == 9) begin
        chk("timeout release grant", 32'(grant), 32'b0000);
      end else begin
        chk("timeout next grant", 32'(grant), 32'b0010);
        chk("timeout next wr_en", 32'(wr_en), 32'd1);
      end
`else
      chk($sformatf("hold k%0d grant", k), 32'(grant), 32'b1000);
      chk($sformatf("hold k%0d wr_en", k), 32'(wr_en), 32'd0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
